// File: rtl/ibexc_dmem_responder.sv
// Fixed-latency data memory responder: byte-masked word array with per-word capability tags.
// Optional forced-error input enabled by defining IBEXC_DMEM_ERR_INJECT_EN.
module ibexc_dmem_responder #(
    parameter int unsigned DataWidth   = 33,
    parameter int unsigned MemWords    = 1024,
    parameter logic [31:0] BaseAddr    = 32'h8000_0000,
    parameter int unsigned RespLatency = 1
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 data_req_i,
    output logic                 data_gnt_o,
    input  logic                 data_we_i,
    input  logic [3:0]           data_be_i,
    input  logic                 data_is_cap_i,
    input  logic [31:0]          data_addr_i,
    input  logic [DataWidth-1:0] data_wdata_i,
    input  logic                 data_stall_i,
`ifdef IBEXC_DMEM_ERR_INJECT_EN
    input  logic                 err_inject_i,
`endif
    output logic                 data_rvalid_o,
    output logic [DataWidth-1:0] data_rdata_o,
    output logic                 data_err_o
);

    localparam int unsigned AddrBits = $clog2(MemWords);

    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_word,
        input logic [31:0] new_word,
        input logic [3:0]  be
    );
        logic [31:0] merged;
        merged = old_word;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) begin
                merged[8*b +: 8] = new_word[8*b +: 8];
            end
        end
        return merged;
    endfunction

    // BaseAddr is aligned to the array size, so range check reduces to matching the upper bits.
    function automatic logic addr_error(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr[31:AddrBits+2] != BaseAddr[31:AddrBits+2]);
    endfunction

    logic [31:0]          mem_r [MemWords];
    logic [MemWords-1:0]  tag_r;

    logic                 stage_valid_r [RespLatency];
    logic                 stage_err_r   [RespLatency];
    logic [DataWidth-1:0] stage_rdata_r [RespLatency];

    logic                 gnt_s;
    logic                 force_err_s;
    logic                 err_s;
    logic                 do_write_s;
    logic [AddrBits-1:0]  index_s;
    logic [DataWidth-1:0] resp_rdata_s;

    assign gnt_s      = data_req_i & ~data_stall_i & ~rst_i;
    assign index_s    = data_addr_i[AddrBits+1:2];
    assign err_s      = addr_error(data_addr_i) | force_err_s;
    assign do_write_s = gnt_s & data_we_i & ~err_s;
    assign data_gnt_o = gnt_s;

`ifdef IBEXC_DMEM_ERR_INJECT_EN
    logic inj_pending_r;

    // Sticky inject request, consumed by the next grant.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inj_pending_r <= 1'b0;
        end else begin
            inj_pending_r <= (inj_pending_r | err_inject_i) & ~gnt_s;
        end
    end

    assign force_err_s = inj_pending_r | err_inject_i;
`else
    assign force_err_s = 1'b0;
`endif

    // Read data for the granted request; writes and errors return zero.
    always_comb begin
        resp_rdata_s = {DataWidth{1'b0}};
        if (!err_s && !data_we_i) begin
            resp_rdata_s = {data_is_cap_i & tag_r[index_s], mem_r[index_s]};
        end else begin
            resp_rdata_s = {DataWidth{1'b0}};
        end
    end

    // Data words are intentionally left unreset.
    always_ff @(posedge clk_i) begin
        if (do_write_s) begin
            mem_r[index_s] <= merge_bytes(mem_r[index_s], data_wdata_i[31:0], data_be_i);
        end
    end

    // Tags survive only full-word capability writes; any other non-empty write clears them.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            tag_r <= {MemWords{1'b0}};
        end else if (do_write_s && (data_be_i != 4'h0)) begin
            tag_r[index_s] <= (data_is_cap_i && (data_be_i == 4'hF)) ? data_wdata_i[DataWidth-1] : 1'b0;
        end
    end

    // Fixed-latency response shift register; the last stage drives the outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int s = 0; s < RespLatency; s++) begin
                stage_valid_r[s] <= 1'b0;
                stage_err_r[s]   <= 1'b0;
                stage_rdata_r[s] <= {DataWidth{1'b0}};
            end
        end else begin
            stage_valid_r[0] <= gnt_s;
            stage_err_r[0]   <= gnt_s & err_s;
            stage_rdata_r[0] <= gnt_s ? resp_rdata_s : {DataWidth{1'b0}};
            for (int s = 1; s < RespLatency; s++) begin
                stage_valid_r[s] <= stage_valid_r[s-1];
                stage_err_r[s]   <= stage_err_r[s-1];
                stage_rdata_r[s] <= stage_rdata_r[s-1];
            end
        end
    end

    assign data_rvalid_o = stage_valid_r[RespLatency-1];
    assign data_err_o    = stage_err_r[RespLatency-1];
    assign data_rdata_o  = stage_rdata_r[RespLatency-1];

endmodule

// File: tb/tb_ibexc_dmem_responder.sv
// Randomized self-checking bench for ibexc_dmem_responder against a word/tag reference model.
// Define IBEXC_DMEM_ERR_INJECT_EN to also exercise the forced-error input.
module tb_ibexc_dmem_responder;

    localparam int          LAT  = 3;
    localparam int          MEMW = 1024;
    localparam logic [31:0] BASE = 32'h8000_0000;

    typedef struct {
        int          cyc;
        logic        err;
        logic [32:0] rdata;
        bit          known;
    } resp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        data_req = 1'b0;
    logic        data_gnt;
    logic        data_we = 1'b0;
    logic [3:0]  data_be = 4'h0;
    logic        data_is_cap = 1'b0;
    logic [31:0] data_addr = 32'h0;
    logic [32:0] data_wdata = 33'h0;
    logic        data_stall = 1'b0;
    logic        data_rvalid;
    logic [32:0] data_rdata;
    logic        data_err;
`ifdef IBEXC_DMEM_ERR_INJECT_EN
    logic        err_inject = 1'b0;
`endif

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [31:0] mem_m [int];
    logic        tag_m [int];
    bit          inj_pending_m = 1'b0;
    resp_t       exp_q [$];
    resp_t       got_q [$];

    ibexc_dmem_responder #(
        .DataWidth(33),
        .MemWords(MEMW),
        .BaseAddr(BASE),
        .RespLatency(LAT)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .data_req_i(data_req),
        .data_gnt_o(data_gnt),
        .data_we_i(data_we),
        .data_be_i(data_be),
        .data_is_cap_i(data_is_cap),
        .data_addr_i(data_addr),
        .data_wdata_i(data_wdata),
        .data_stall_i(data_stall),
`ifdef IBEXC_DMEM_ERR_INJECT_EN
        .err_inject_i(err_inject),
`endif
        .data_rvalid_o(data_rvalid),
        .data_rdata_o(data_rdata),
        .data_err_o(data_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (data_rvalid === 1'b1) begin
            got_q.push_back('{cyc, data_err, data_rdata, 1'b1});
        end
    end

    // Reference behaviour: byte address -> word slot, error rules, tag rules.
    function automatic resp_t model_access(input logic we, input logic [3:0] be, input logic cap,
                                           input logic [31:0] addr, input logic [32:0] wdata,
                                           input bit force_err);
        resp_t       r;
        longint      off;
        int          idx;
        logic [31:0] word;
        r.cyc = 0; r.err = 1'b0; r.rdata = 33'h0; r.known = 1'b1;
        off = longint'(addr) - longint'(BASE);
        if (force_err || (addr % 4 != 0) || off < 0 || off >= longint'(MEMW) * 4) begin
            r.err = 1'b1;
            return r;
        end
        idx = int'(off / 4);
        if (we) begin
            word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
            for (int b = 0; b < 4; b++) begin
                if (be[b]) word[8*b +: 8] = wdata[8*b +: 8];
            end
            if (mem_m.exists(idx) || be == 4'hF) mem_m[idx] = word;
            if (be == 4'hF && cap) tag_m[idx] = wdata[32];
            else if (be != 4'h0) tag_m[idx] = 1'b0;
        end else begin
            r.known = mem_m.exists(idx);
            r.rdata[31:0] = r.known ? mem_m[idx] : 32'h0;
            r.rdata[32]   = (cap && tag_m.exists(idx)) ? tag_m[idx] : 1'b0;
        end
        return r;
    endfunction

    // Drive one request from a negedge until granted; returns at the following negedge.
    task automatic issue(input logic we, input logic [3:0] be, input logic cap, input logic [31:0] addr,
                         input logic [32:0] wdata, output int waited, output int gcyc);
        resp_t e;
        data_req = 1'b1; data_we = we; data_be = be; data_is_cap = cap;
        data_addr = addr; data_wdata = wdata;
        waited = 0;
        gcyc = -1;
        #1;
        while (data_gnt !== 1'b1 && waited < 20) begin
            @(negedge clk); #1;
            waited++;
        end
        if (data_gnt === 1'b1) begin
            e = model_access(we, be, cap, addr, wdata, inj_pending_m);
            inj_pending_m = 1'b0;
            gcyc = cyc;
            e.cyc = cyc + LAT;
            exp_q.push_back(e);
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        data_req = 1'b0; data_we = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset();
        data_req = 1'b1;
        #1 rst = 1'b1;
        @(negedge clk); #1;
        checks++; if (data_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid got %b want 0", data_rvalid); end
        checks++; if (data_rdata !== 33'h0) begin errors++; $display("FAIL reset_rdata got %h want 0", data_rdata); end
        checks++; if (data_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", data_err); end
        checks++; if (data_gnt !== 1'b0) begin errors++; $display("FAIL reset_gnt got %b want 0", data_gnt); end
        data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        idle(2);
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL reset_no_rvalid got %0d want 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_write_read();
        resp_t e, g, seen[$];
        int w, gw, gr;
        issue(1'b1, 4'hF, 1'b0, 32'h8000_0010, 33'h0_DEADBEEF, w, gw);
        issue(1'b0, 4'hF, 1'b0, 32'h8000_0010, 33'h0, w, gr);
        idle(LAT + 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL wr_rd missing response, want cyc %0d", e.cyc); end
            else begin
                g = got_q.pop_front(); seen.push_back(g);
                if (g.cyc !== e.cyc || g.err !== e.err || (e.known && g.rdata !== e.rdata)) begin
                    errors++; $display("FAIL wr_rd got cyc %0d err %b rdata %h want cyc %0d err %b rdata %h", g.cyc, g.err, g.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL wr_rd extra rvalid got %0d want 0", got_q.size()); got_q.delete(); end
        if (seen.size() == 2) begin
            checks++; if (seen[1].rdata !== 33'h0_DEADBEEF || seen[1].cyc != gr + LAT) begin
                errors++; $display("FAIL wr_rd_value got %h at cyc %0d want 0deadbeef at cyc %0d", seen[1].rdata, seen[1].cyc, gr + LAT);
            end
        end
    endtask

    task automatic test_byte_mask_tag();
        resp_t e, g, seen[$];
        int w, gc;
        issue(1'b1, 4'hF, 1'b1, 32'h8000_0020, 33'h1_11223344, w, gc);
        issue(1'b0, 4'hF, 1'b1, 32'h8000_0020, 33'h0, w, gc);
        issue(1'b0, 4'hF, 1'b0, 32'h8000_0020, 33'h0, w, gc);
        issue(1'b1, 4'b0010, 1'b0, 32'h8000_0020, 33'h0_0000AA00, w, gc);
        issue(1'b1, 4'h0, 1'b1, 32'h8000_0020, 33'h1_FFFFFFFF, w, gc);
        issue(1'b0, 4'h0, 1'b1, 32'h8000_0020, 33'h0, w, gc);
        idle(LAT + 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL mask_tag missing response, want cyc %0d", e.cyc); end
            else begin
                g = got_q.pop_front(); seen.push_back(g);
                if (g.cyc !== e.cyc || g.err !== e.err || (e.known && g.rdata !== e.rdata)) begin
                    errors++; $display("FAIL mask_tag got cyc %0d err %b rdata %h want cyc %0d err %b rdata %h", g.cyc, g.err, g.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL mask_tag extra rvalid got %0d want 0", got_q.size()); got_q.delete(); end
        if (seen.size() == 6) begin
            checks++; if (seen[1].rdata !== 33'h1_11223344) begin errors++; $display("FAIL cap_read got %h want 111223344", seen[1].rdata); end
            checks++; if (seen[2].rdata !== 33'h0_11223344) begin errors++; $display("FAIL noncap_read got %h want 011223344", seen[2].rdata); end
            checks++; if (seen[5].rdata !== 33'h0_1122AA44) begin errors++; $display("FAIL masked_read got %h want 01122aa44", seen[5].rdata); end
        end
    endtask

    task automatic test_errors();
        resp_t e, g, seen[$];
        int w, gc;
        issue(1'b1, 4'hF, 1'b0, 32'h8000_0000, 33'h0_A5A55A5A, w, gc);
        issue(1'b0, 4'hF, 1'b0, 32'h8000_1000, 33'h0, w, gc);
        issue(1'b1, 4'hF, 1'b1, 32'h8000_0002, 33'h1_FFFFFFFF, w, gc);
        issue(1'b0, 4'hF, 1'b0, 32'h7FFF_FFFC, 33'h0, w, gc);
        issue(1'b0, 4'hF, 1'b1, 32'h8000_0000, 33'h0, w, gc);
        idle(LAT + 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL errors missing response, want cyc %0d", e.cyc); end
            else begin
                g = got_q.pop_front(); seen.push_back(g);
                if (g.cyc !== e.cyc || g.err !== e.err || (e.known && g.rdata !== e.rdata)) begin
                    errors++; $display("FAIL errors got cyc %0d err %b rdata %h want cyc %0d err %b rdata %h", g.cyc, g.err, g.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL errors extra rvalid got %0d want 0", got_q.size()); got_q.delete(); end
        if (seen.size() == 5) begin
            checks++; if (seen[1].err !== 1'b1 || seen[1].rdata !== 33'h0) begin errors++; $display("FAIL oob_read got err %b rdata %h want err 1 rdata 0", seen[1].err, seen[1].rdata); end
            checks++; if (seen[2].err !== 1'b1) begin errors++; $display("FAIL misaligned_write got err %b want 1", seen[2].err); end
            checks++; if (seen[4].rdata !== 33'h0_A5A55A5A) begin errors++; $display("FAIL err_no_modify got %h want 0a5a55a5a", seen[4].rdata); end
        end
    endtask

    task automatic test_back_to_back();
        resp_t e, g, seen[$];
        int w, gc;
        for (int i = 0; i < 4; i++) begin
            issue(1'b1, 4'hF, 1'b0, BASE + 32'(4 * i), {1'b0, 32'h1000_0000 + 32'(i * 32'h111)}, w, gc);
        end
        idle(1);
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 4'hF, 1'b0, BASE + 32'(4 * i), 33'h0, w, gc);
        end
        idle(LAT + 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL b2b missing response, want cyc %0d", e.cyc); end
            else begin
                g = got_q.pop_front(); seen.push_back(g);
                if (g.cyc !== e.cyc || g.err !== e.err || (e.known && g.rdata !== e.rdata)) begin
                    errors++; $display("FAIL b2b got cyc %0d err %b rdata %h want cyc %0d err %b rdata %h", g.cyc, g.err, g.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL b2b extra rvalid got %0d want 0", got_q.size()); got_q.delete(); end
        if (seen.size() == 8) begin
            for (int i = 1; i < 4; i++) begin
                checks++; if (seen[4+i].cyc != seen[4].cyc + i) begin errors++; $display("FAIL b2b_consecutive got cyc %0d want %0d", seen[4+i].cyc, seen[4].cyc + i); end
            end
        end
    endtask

    task automatic test_stall();
        resp_t e, g;
        int w, gc;
        data_stall = 1'b1;
        data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_is_cap = 1'b0; data_addr = 32'h8000_0004;
        for (int i = 0; i < 5; i++) begin
            #1;
            checks++; if (data_gnt !== 1'b0) begin errors++; $display("FAIL stall_gnt cycle %0d got %b want 0", i, data_gnt); end
            @(negedge clk);
        end
        data_stall = 1'b0;
        issue(1'b0, 4'hF, 1'b0, 32'h8000_0004, 33'h0, w, gc);
        checks++; if (w != 0) begin errors++; $display("FAIL stall_release got wait %0d want 0", w); end
        idle(LAT + 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL stall missing response, want cyc %0d", e.cyc); end
            else begin
                g = got_q.pop_front();
                if (g.cyc !== e.cyc || g.err !== e.err || (e.known && g.rdata !== e.rdata)) begin
                    errors++; $display("FAIL stall got cyc %0d err %b rdata %h want cyc %0d err %b rdata %h", g.cyc, g.err, g.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL stall extra rvalid got %0d want 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_reset_midflight();
        resp_t e, g, keep[$];
        int w, gc;
        for (int i = 0; i < 4; i++) begin
            issue(1'b0, 4'hF, 1'b0, BASE + 32'(4 * i), 33'h0, w, gc);
        end
        #2 rst = 1'b1;
        #1;
        checks++; if (data_rvalid !== 1'b0 || data_rdata !== 33'h0 || data_err !== 1'b0) begin
            errors++; $display("FAIL rst_flight_outputs got rvalid %b rdata %h err %b want 0 0 0", data_rvalid, data_rdata, data_err);
        end
        checks++; if (data_gnt !== 1'b0) begin errors++; $display("FAIL rst_flight_gnt got %b want 0", data_gnt); end
        foreach (exp_q[i]) if (exp_q[i].cyc <= cyc) keep.push_back(exp_q[i]);
        exp_q = keep;
        tag_m.delete();
        inj_pending_m = 1'b0;
        data_req = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(LAT + 4);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL rst_flight missing response, want cyc %0d", e.cyc); end
            else begin
                g = got_q.pop_front();
                if (g.cyc !== e.cyc || g.err !== e.err || (e.known && g.rdata !== e.rdata)) begin
                    errors++; $display("FAIL rst_flight got cyc %0d err %b rdata %h want cyc %0d err %b rdata %h", g.cyc, g.err, g.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rst_flight extra rvalid got %0d want 0", got_q.size()); got_q.delete(); end
    endtask

    task automatic test_random();
        resp_t e, g;
        int w, gc, sel;
        logic [31:0] a;
        for (int i = 0; i < 16; i++) begin
            issue(1'b1, 4'hF, 1'($urandom_range(0, 1)), BASE + 32'(4 * i), {1'($urandom_range(0, 1)), 32'($urandom)}, w, gc);
        end
        for (int n = 0; n < 200; n++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 8) a = BASE + 32'(4 * $urandom_range(0, 15));
            else if (sel == 8) a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
            else if ($urandom_range(0, 1) == 0) a = BASE - 32'd4;
            else a = BASE + 32'h1000 + 32'(4 * $urandom_range(0, 15));
            issue(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)), a,
                  {1'($urandom_range(0, 1)), 32'($urandom)}, w, gc);
            checks++; if (w != 0) begin errors++; $display("FAIL rand_gnt got wait %0d want 0", w); end
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
        end
        idle(LAT + 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL rand missing response, want cyc %0d", e.cyc); end
            else begin
                g = got_q.pop_front();
                if (g.cyc !== e.cyc || g.err !== e.err || (e.known && g.rdata !== e.rdata)) begin
                    errors++; $display("FAIL rand got cyc %0d err %b rdata %h want cyc %0d err %b rdata %h", g.cyc, g.err, g.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rand extra rvalid got %0d want 0", got_q.size()); got_q.delete(); end
    endtask

`ifdef IBEXC_DMEM_ERR_INJECT_EN
    task automatic test_err_inject();
        resp_t e, g, seen[$];
        int w, gc;
        issue(1'b1, 4'hF, 1'b0, 32'h8000_0040, 33'h0_CAFEF00D, w, gc);
        idle(1);
        err_inject = 1'b1;
        inj_pending_m = 1'b1;
        @(negedge clk);
        err_inject = 1'b0;
        idle(2);
        issue(1'b1, 4'hF, 1'b0, 32'h8000_0040, 33'h0_12345678, w, gc);
        issue(1'b0, 4'hF, 1'b0, 32'h8000_0040, 33'h0, w, gc);
        idle(LAT + 2);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (got_q.size() == 0) begin errors++; $display("FAIL inject missing response, want cyc %0d", e.cyc); end
            else begin
                g = got_q.pop_front(); seen.push_back(g);
                if (g.cyc !== e.cyc || g.err !== e.err || (e.known && g.rdata !== e.rdata)) begin
                    errors++; $display("FAIL inject got cyc %0d err %b rdata %h want cyc %0d err %b rdata %h", g.cyc, g.err, g.rdata, e.cyc, e.err, e.rdata);
                end
            end
        end
        checks++; if (got_q.size() != 0) begin errors++; $display("FAIL inject extra rvalid got %0d want 0", got_q.size()); got_q.delete(); end
        if (seen.size() == 3) begin
            checks++; if (seen[1].err !== 1'b1) begin errors++; $display("FAIL inject_err got %b want 1", seen[1].err); end
            checks++; if (seen[2].err !== 1'b0 || seen[2].rdata !== 33'h0_CAFEF00D) begin
                errors++; $display("FAIL inject_after got err %b rdata %h want err 0 rdata 0cafef00d", seen[2].err, seen[2].rdata);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_write_read();
        test_byte_mask_tag();
        test_errors();
        test_back_to_back();
        test_stall();
        test_reset_midflight();
        test_random();
`ifdef IBEXC_DMEM_ERR_INJECT_EN
        test_err_inject();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ibexc_dmem_responder.md
# ibexc_dmem_responder

Memory-side responder for the core's data memory interface. It accepts req/gnt requests, performs byte-masked reads and writes against a local word array with a per-word capability tag bit, and returns in-order rvalid responses after a fixed latency. It sits on the data bus opposite the core's load/store unit, in simulation benches and small FPGA integrations. It also flags out-of-range and misaligned accesses as bus errors.

## Interface
- DataWidth, 33: data word width; bit 32 is the capability tag, bits 31:0 are data.
- MemWords, 1024: number of 32-bit words in the array, power of two.
- BaseAddr, 32'h8000_0000: byte address of word 0, aligned to MemWords*4.
- RespLatency, 1: cycles from grant edge to rvalid, 1..4.

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_i  in  1  asynchronous, active-high reset.
- data_req_i  in  1  request valid.
- data_gnt_o  out  1  request accepted this cycle; combinational.
- data_we_i  in  1  1 = write, 0 = read.
- data_be_i  in  4  byte enables for bits 31:0.
- data_is_cap_i  in  1  capability access; tag bit is meaningful.
- data_addr_i  in  32  byte address.
- data_wdata_i  in  DataWidth  write data; bit 32 is the tag.
- data_stall_i  in  1  bench-driven grant suppression.
- data_rvalid_o  out  1  response valid, one cycle per granted request.
- data_rdata_o  out  DataWidth  read data; 0 for writes and errors.
- data_err_o  out  1  error for this response; qualified by rvalid.

## Operation
- Grant: data_gnt_o = data_req_i & ~data_stall_i & ~rst_i. One request is accepted per cycle. No limit on outstanding requests, because the pipeline is fixed-latency.
- Address check on a granted request:
  - index = (addr - BaseAddr) >> 2.
  - Error if addr[1:0] != 0, or if addr is outside [BaseAddr, BaseAddr + MemWords*4).
  - An error access does not modify memory or tags. Its response has err = 1 and rdata = 0.
- Write, granted without error, takes effect at the grant edge:
  - Each byte i of data with be[i] = 1 is updated.
  - Tag update:
    - tag <= wdata[32] only if is_cap and be = 4'hF.
    - Any other write with be != 0 clears the tag.
    - be = 0 leaves data and tag unchanged, and the response is still returned.
  - Response: rdata = 0, err = 0.
- Read, granted without error:
  - Word and tag are sampled at the grant edge, after any write committed on that same edge (there is none, since there is one request per cycle).
  - rdata[31:0] = word, ignoring be.
  - rdata[32] = tag if is_cap, else 0.
- Response pipeline:
  - Shift register of RespLatency stages, each holding {valid, err, rdata}.
  - Stage 0 is loaded on a grant and cleared otherwise.
  - The last stage drives the outputs directly.
  - Responses are returned strictly in grant order. There is no backpressure on rvalid.

## Timing
- Grant in cycle N gives rvalid high in cycle N + RespLatency, for exactly one cycle.
- Back-to-back grants give back-to-back rvalids.
- Read after write: a read granted in cycle N+1 returns data written by a write granted in cycle N.
- Reset values: data_rvalid_o = 0, data_rdata_o = 0, data_err_o = 0, all pipeline valid bits 0, all tag bits 0. Data words are not reset.
- data_gnt_o is 0 while rst_i is high.
- Reset mid-operation: all in-flight responses are discarded and no rvalid is produced for them. A write granted on the edge where rst_i asserts is not guaranteed.
- Stall: with data_stall_i high the request stays pending and the requester holds its signals. Responses already in flight still complete.

## Configuration
- IBEXC_DMEM_ERR_INJECT_EN defined:
  - Adds input err_inject_i (1 bit).
  - The first grant at or after a cycle with err_inject_i = 1 is forced to error: no write, err = 1, rdata = 0.
  - A one-bit sticky pending flag latches the inject. It clears on that grant and resets to 0.
- Undefined: the port is absent and errors arise only from the address check.

## Test plan
- Word write, then read:
  - Write addr 0x8000_0010, be F, wdata 0x0_DEADBEEF.
  - Read the same address with is_cap = 0.
  - Expect rvalid at grant + RespLatency, rdata 0x0_DEADBEEF, err = 0.
- Byte-masked write and tag clear:
  - Capability write to 0x8000_0020: wdata 0x1_11223344, be F, is_cap = 1.
  - Then write be 4'b0010, wdata 0x0000AA00.
  - Capability read returns 0x0_1122AA44, tag cleared.
- Errors:
  - Read 0x8000_1000 (MemWords = 1024) gives err = 1, rdata = 0.
  - Write 0x8000_0002 gives err = 1, and memory is unchanged when read back.
- Pipelining with RespLatency = 3:
  - Four back-to-back reads of 0x8000_0000/4/8/C.
  - Expect rvalid in four consecutive cycles, data in order.
- Stall and reset:
  - Stall 5 cycles: no grant during the stall; grant on the first cycle after it is released.
  - Assert rst_i with 2 responses in flight: no rvalid follows, and outputs read 0 immediately.
- Error inject (macro defined):
  - Pulse err_inject_i, then write 0x8000_0040.
  - Expect err = 1 and the word unchanged. The next access is normal.
